// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - cpu_defs: opcodes, functs, ALU codes, decode types
// Shared by the decoder, the ID stage top and its bus interface.
package cpu_defs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_LUI = 4'd6;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_sel_e;
  typedef enum logic [2:0] {IMM_ZERO, IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_JUMP, IMM_SHAMT} imm_kind_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       link;
    logic [3:0] alu_op;
    dst_sel_e   dst_sel;
    imm_kind_e  imm_kind;
    logic       uses_rt;
  } ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  branch;
    logic                  bne;
    logic                  jump;
    logic                  link;
    logic [3:0]            alu_op;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [DATA_W-1:0]     pc_plus4;
  } idex_t;

  // Jump targets stay word-aligned and PC-relative bits are left to EX.
  function automatic logic [DATA_W-1:0] extend_imm(imm_kind_e kind, logic [31:0] instr);
    logic [DATA_W-1:0] imm;
    imm = '0;
    case (kind)
      IMM_SEXT:  imm = {{16{instr[15]}}, instr[15:0]};
      IMM_ZEXT:  imm = {16'h0, instr[15:0]};
      IMM_LUI:   imm = {instr[15:0], 16'h0};
      IMM_JUMP:  imm = {4'h0, instr[25:0], 2'b00};
      IMM_SHAMT: imm = {27'h0, instr[10:6]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - IF/RF/WB/EX-facing bus of the ID stage
// slave: ID stage side; master: surrounding pipeline (or testbench) side.
interface decode_stage_if;
  import cpu_defs::*;

  logic                  if_valid;
  logic [31:0]           if_instr;
  logic [DATA_W-1:0]     if_pc_plus4;
  logic                  id_ready;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rf_read_reg_1;
  logic [REG_ADDR_W-1:0] rf_read_reg_2;
  logic [DATA_W-1:0]     rf_read_data_1;
  logic [DATA_W-1:0]     rf_read_data_2;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_write_reg;
  logic [DATA_W-1:0]     wb_write_data;
  logic                  ex_ready;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_alu_src;
  logic                  ex_branch;
  logic                  ex_bne;
  logic                  ex_jump;
  logic                  ex_link;
  logic [3:0]            ex_alu_op;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_dst_reg;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [DATA_W-1:0]     ex_pc_plus4;

  modport slave (
    input  if_valid, if_instr, if_pc_plus4, flush,
    input  rf_read_data_1, rf_read_data_2,
    input  wb_reg_write, wb_write_reg, wb_write_data, ex_ready,
    output id_ready, rf_read_reg_1, rf_read_reg_2, ex_valid,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
    output ex_branch, ex_bne, ex_jump, ex_link, ex_alu_op,
    output ex_rs_data, ex_rt_data, ex_imm, ex_dst_reg, ex_rs, ex_rt, ex_pc_plus4
  );

  modport master (
    output if_valid, if_instr, if_pc_plus4, flush,
    output rf_read_data_1, rf_read_data_2,
    output wb_reg_write, wb_write_reg, wb_write_data, ex_ready,
    input  id_ready, rf_read_reg_1, rf_read_reg_2, ex_valid,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
    input  ex_branch, ex_bne, ex_jump, ex_link, ex_alu_op,
    input  ex_rs_data, ex_rt_data, ex_imm, ex_dst_reg, ex_rs, ex_rt, ex_pc_plus4
  );

endinterface

// File: rtl/decode_stage_control_decoder.sv
// rtl/decode_stage_control_decoder.sv - opcode/funct to control bits
// Ports: opcode, funct in; ctrl (controls, alu_op, dst select, imm kind, uses_rt) out.
module control_decoder
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.dst_sel   = DST_RD;
        ctrl.uses_rt   = 1'b1;
        case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op   = ALU_SLL;
            ctrl.imm_kind = IMM_SHAMT;
          end
          default: ctrl = '0;  // unsupported funct (incl. jr) is a NOP
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.dst_sel   = DST_RT;
        ctrl.mem_read  = (opcode == OP_LW);
        case (opcode)
          OP_SLTI: begin ctrl.alu_op = ALU_SLT; ctrl.imm_kind = IMM_SEXT; end
          OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.imm_kind = IMM_ZEXT; end
          OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.imm_kind = IMM_ZEXT; end
          OP_LUI:  begin ctrl.alu_op = ALU_LUI; ctrl.imm_kind = IMM_LUI;  end
          default: begin ctrl.alu_op = ALU_ADD; ctrl.imm_kind = IMM_SEXT; end
        endcase
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.imm_kind  = IMM_SEXT;
        ctrl.dst_sel   = DST_RT;
        ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = 1'b1;
        ctrl.bne      = (opcode == OP_BNE);
        ctrl.alu_op   = ALU_SUB;
        ctrl.imm_kind = IMM_SEXT;
        ctrl.dst_sel  = DST_RT;
        ctrl.uses_rt  = 1'b1;
      end
      OP_J: begin
        ctrl.jump     = 1'b1;
        ctrl.imm_kind = IMM_JUMP;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.imm_kind  = IMM_JUMP;
        ctrl.dst_sel   = DST_RA;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: RF addressing, WB bypass, load-use stall, ID/EX register
// Ports: clk, reset (async, active-high); bus (decode_stage_if.slave) carries
// IF handshake, RF read port, WB bypass, flush and the ID/EX outputs to EX.
module decode_stage
  import cpu_defs::*;
(
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rs_data, rt_data;
  ctrl_t                 ctrl;
  idex_t                 decoded, idex_d, idex_q;
  logic                  ex_valid_d, ex_valid_q;
  logic                  load_use, adv;

  assign rs = bus.if_instr[25:21];
  assign rt = bus.if_instr[20:16];
  assign rd = bus.if_instr[15:11];

  assign bus.rf_read_reg_1 = rs;
  assign bus.rf_read_reg_2 = rt;

  control_decoder u_control_decoder (
    .opcode (bus.if_instr[31:26]),
    .funct  (bus.if_instr[5:0]),
    .ctrl   (ctrl)
  );

  // The RF read happens in the same cycle WB writes, so a matching WB write
  // must override the (stale) RF value.
  always_comb begin
    rs_data = bus.rf_read_data_1;
    rt_data = bus.rf_read_data_2;
    if (rs == '0) rs_data = '0;
    else if (bus.wb_reg_write && bus.wb_write_reg == rs) rs_data = bus.wb_write_data;
    if (rt == '0) rt_data = '0;
    else if (bus.wb_reg_write && bus.wb_write_reg == rt) rt_data = bus.wb_write_data;
  end

  always_comb begin
    decoded           = '0;
    decoded.reg_write = ctrl.reg_write;
    decoded.mem_read  = ctrl.mem_read;
    decoded.mem_write = ctrl.mem_write;
    decoded.alu_src   = ctrl.alu_src;
    decoded.branch    = ctrl.branch;
    decoded.bne       = ctrl.bne;
    decoded.jump      = ctrl.jump;
    decoded.link      = ctrl.link;
    decoded.alu_op    = ctrl.alu_op;
    decoded.rs_data   = rs_data;
    decoded.rt_data   = rt_data;
    decoded.imm       = extend_imm(ctrl.imm_kind, bus.if_instr);
    decoded.rs        = rs;
    decoded.rt        = rt;
    decoded.pc_plus4  = bus.if_pc_plus4;
    case (ctrl.dst_sel)
      DST_RD:  decoded.dst_reg = rd;
      DST_RT:  decoded.dst_reg = rt;
      DST_RA:  decoded.dst_reg = REG_ADDR_W'(31);
      default: decoded.dst_reg = '0;
    endcase
  end

  // rs is compared for every instruction; rt only when it is a real source.
  assign load_use = ex_valid_q && idex_q.mem_read && (idex_q.dst_reg != '0) &&
                    ((idex_q.dst_reg == rs) || (idex_q.dst_reg == rt && ctrl.uses_rt));
  assign adv      = !ex_valid_q || bus.ex_ready;
  assign bus.id_ready = bus.flush || (adv && !load_use);

  always_comb begin
    idex_d     = idex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (adv && load_use) begin
      ex_valid_d = 1'b0;
    end else if (adv) begin
      idex_d     = decoded;
      ex_valid_d = bus.if_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q     <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      idex_q     <= idex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_reg_write = idex_q.reg_write;
  assign bus.ex_mem_read  = idex_q.mem_read;
  assign bus.ex_mem_write = idex_q.mem_write;
  assign bus.ex_alu_src   = idex_q.alu_src;
  assign bus.ex_branch    = idex_q.branch;
  assign bus.ex_bne       = idex_q.bne;
  assign bus.ex_jump      = idex_q.jump;
  assign bus.ex_link      = idex_q.link;
  assign bus.ex_alu_op    = idex_q.alu_op;
  assign bus.ex_rs_data   = idex_q.rs_data;
  assign bus.ex_rt_data   = idex_q.rt_data;
  assign bus.ex_imm       = idex_q.imm;
  assign bus.ex_dst_reg   = idex_q.dst_reg;
  assign bus.ex_rs        = idex_q.rs;
  assign bus.ex_rt        = idex_q.rt;
  assign bus.ex_pc_plus4  = idex_q.pc_plus4;

endmodule
